// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the fetch controller
// Purpose: widths, instruction size, the NOP returned by an empty buffer and the
//          fetch FSM state type.
// Ports:   none (package).
package fetch_pkg;

    localparam int          XLEN       = 32;
    localparam int          INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - imem request/response and decode handoff bundle
// Purpose: groups the instruction-memory handshake and the decode handoff.
// Ports:   master = fetch controller side, slave = memory/decode side.
//          imem_req_valid/ready/addr, imem_rsp_valid/data, inst_valid/ready/word/pc.
interface fetch_if #(
    parameter int XLEN = fetch_pkg::XLEN
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_word;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_word, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_word, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small FIFO of fetched {pc, word} pairs
// Purpose: holds returned instructions until decode takes them; head is read
//          combinationally. flush empties it in one cycle.
// Ports:   clk, reset (async active-low), flush, push/push_pc/push_word,
//          pop, head_pc/head_word (0 / NOP when empty), count, empty, full.
module fetch_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_word,
    input  logic            pop,
    output logic [XLEN-1:0] head_pc,
    output logic [31:0]     head_word,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full
);
    import fetch_pkg::*;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     word_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            pop_ok;
    logic            push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            pc_mem[wr_ptr]   <= push_pc;
            word_mem[wr_ptr] <= push_word;
        end
    end

    assign head_pc   = empty ? '0       : pc_mem[rd_ptr];
    assign head_word = empty ? NOP_INST : word_mem[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC owner and single-outstanding imem fetch sequencer
// Purpose: issues one imem request at a time, buffers returned words with their
//          PC for decode, and handles stall, backpressure and redirects
//          (squashing a response already in flight).
// Ports:   clk, reset (async active-low), stall, redirect_valid, redirect_pc,
//          bus (fetch_if.master: imem request/response, decode handoff).
module fetch_controller #(
    parameter int              XLEN      = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_if.master         bus
);
    import fetch_pkg::*;

    localparam int            CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_V = (CW+1)'(BUF_DEPTH);
    localparam logic [XLEN-1:0] ALIGN = XLEN'(INST_BYTES - 1);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            still_outstanding;
    logic [CW:0]     fill_after;
    logic [CW-1:0]   buf_count;
    logic            buf_empty;
    logic            buf_full;

    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = !buf_empty;

    assign req_fire = (state_q == REQ) && bus.imem_req_ready;
    assign push     = (state_q == WAIT) && bus.imem_rsp_valid && !redirect_valid;
    assign pop      = !buf_empty && bus.inst_ready;
    // A response is still owed after this edge if one was just accepted or the
    // awaited one has not arrived yet; a redirect must then squash it via DROP.
    assign still_outstanding = req_fire ||
        (((state_q == WAIT) || (state_q == DROP)) && !bus.imem_rsp_valid);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fill_after = (CW+1)'(buf_count) + (CW+1)'(push) - (CW+1)'(pop);
        case (state_q)
            IDLE: if (!stall && !buf_full) state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    pc_d    = pc_q + XLEN'(INST_BYTES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid)
                    state_d = (!stall && (fill_after < DEPTH_V)) ? REQ : IDLE;
            end
            DROP: if (bus.imem_rsp_valid) state_d = stall ? IDLE : REQ;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ALIGN;
            if (still_outstanding) state_d = DROP;
            else if (stall)        state_d = IDLE;
            else                   state_d = REQ;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (req_fire) req_pc_q <= pc_q;
        end
    end

    fetch_buffer #(
        .XLEN  (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_pc   (req_pc_q),
        .push_word (bus.imem_rsp_data),
        .pop       (pop),
        .head_pc   (bus.inst_pc),
        .head_word (bus.inst_word),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
module tb_fetch_controller;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_if #(.XLEN(32)) u_if ();
    fetch_if #(.XLEN(32)) u_if2 ();

    fetch_controller #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .reset(rst_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .bus(u_if.master)
    );

    fetch_controller #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)
    ) u_dut2 (
        .clk(clk), .reset(rst_n), .stall(1'b0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .bus(u_if2.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // memory controls
    logic        mem_auto  = 1'b1;
    int          mem_delay = 1;
    logic        man_rsp   = 1'b0;
    logic [31:0] man_data  = 32'h0;

    // model state and logs
    logic [31:0] mq_pc[$];
    logic [31:0] mq_word[$];
    logic [31:0] req_log[$];
    logic [31:0] req2_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_word[$];
    int          del_cyc[$];
    logic        out_vld = 0, out_stale = 0;
    logic [31:0] out_pc = 0, exp_pc = 0;
    logic        prev_valid = 0, prev_fire = 0, prev_stall = 0;
    logic        mem_fire = 0, fire2 = 0;
    logic [31:0] mem_fire_addr = 0, fire2_addr = 0;

    // compare process + abstract model: outputs after edge k are checked at the
    // following negedge, then the events of edge k+1 are applied to the model.
    always @(negedge clk) begin : mon
        logic fire, rsp, pop;
        cyc++;
        if (!rst_n) begin
            mq_pc.delete(); mq_word.delete(); req2_log.delete();
            out_vld = 0; out_stale = 0; exp_pc = 32'h0;
            prev_valid = 0; prev_fire = 0; prev_stall = stall;
            mem_fire = 0; fire2 = 0;
            chk("rst_req_valid", 32'(u_if.imem_req_valid), 32'd0);
            chk("rst_inst_valid", 32'(u_if.inst_valid), 32'd0);
            chk("rst_req_addr", u_if.imem_req_addr, 32'h0);
            chk("rst_inst_word", u_if.inst_word, NOP_INST);
            chk("rst_inst_pc", u_if.inst_pc, 32'h0);
        end else begin
            chk("inst_valid", 32'(u_if.inst_valid), 32'(mq_pc.size() != 0));
            if (mq_pc.size() != 0) begin
                chk("inst_pc", u_if.inst_pc, mq_pc[0]);
                chk("inst_word", u_if.inst_word, mq_word[0]);
            end else begin
                chk("inst_pc_empty", u_if.inst_pc, 32'h0);
                chk("inst_word_empty", u_if.inst_word, NOP_INST);
            end
            if (u_if.imem_req_valid) begin
                chk("req_addr", u_if.imem_req_addr, exp_pc);
                chk("req_one_outstanding", 32'(out_vld), 32'd0);
                chk("req_issue_rule", 32'(mq_pc.size() < DEPTH), 32'd1);
                if (!prev_valid || prev_fire)
                    chk("req_started_under_stall", 32'(prev_stall), 32'd0);
            end
            fire = u_if.imem_req_valid && u_if.imem_req_ready;
            rsp  = u_if.imem_rsp_valid && out_vld;
            pop  = (mq_pc.size() != 0) && u_if.inst_ready;
            if (fire) req_log.push_back(u_if.imem_req_addr);
            if (pop) begin
                del_pc.push_back(mq_pc[0]);
                del_word.push_back(mq_word[0]);
                del_cyc.push_back(cyc);
            end
            if (redirect_valid) begin
                mq_pc.delete(); mq_word.delete();
                if (rsp) out_vld = 0;
                else if (out_vld) out_stale = 1;
                if (fire) begin
                    out_vld = 1; out_pc = u_if.imem_req_addr; out_stale = 1;
                end
                exp_pc = redirect_pc & ~32'h3;
            end else begin
                if (pop) begin
                    void'(mq_pc.pop_front()); void'(mq_word.pop_front());
                end
                if (rsp) begin
                    if (!out_stale) begin
                        mq_pc.push_back(out_pc); mq_word.push_back(memf(out_pc));
                    end
                    out_vld = 0;
                end
                if (fire) begin
                    out_vld = 1; out_pc = u_if.imem_req_addr; out_stale = 0;
                    exp_pc = u_if.imem_req_addr + 32'd4;
                end
            end
            prev_valid = u_if.imem_req_valid; prev_fire = fire; prev_stall = stall;
            mem_fire = fire; mem_fire_addr = u_if.imem_req_addr;
            fire2 = u_if2.imem_req_valid && u_if2.imem_req_ready;
            fire2_addr = u_if2.imem_req_addr;
            if (fire2) req2_log.push_back(u_if2.imem_req_addr);
        end
    end

    // memory responders
    initial begin : mem
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 0; cnt = 0; paddr = 0;
        u_if.imem_rsp_valid  = 1'b0; u_if.imem_rsp_data  = 32'h0;
        u_if2.imem_rsp_valid = 1'b0; u_if2.imem_rsp_data = 32'h0;
        forever begin
            @(posedge clk); #2;
            u_if2.imem_rsp_valid = fire2;
            u_if2.imem_rsp_data  = memf(fire2_addr);
            if (!rst_n) pend = 0;
            if (mem_auto) begin
                u_if.imem_rsp_valid = 1'b0;
                if (mem_fire && rst_n) begin
                    pend = 1; cnt = mem_delay; paddr = mem_fire_addr;
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        u_if.imem_rsp_valid = 1'b1;
                        u_if.imem_rsp_data  = memf(paddr);
                        pend = 0;
                    end
                end
            end else begin
                pend = 0;
                u_if.imem_rsp_valid = man_rsp;
                u_if.imem_rsp_data  = man_data;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete(); del_pc.delete(); del_word.delete(); del_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input int n, input int budget, input string name);
        int i = 0;
        while (req_log.size() < n && i < budget) begin
            step(1);
            i++;
        end
        if (req_log.size() < n) chk(name, 32'(req_log.size()), 32'(n));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int n8;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        u_if.imem_req_ready  = 1'b1; u_if.inst_ready  = 1'b1;
        u_if2.imem_req_ready = 1'b1; u_if2.inst_ready = 1'b1;

        // T1: streaming fetch, 1-cycle memory
        do_reset();
        chk("t1_req_at_release", 32'(u_if.imem_req_valid), 32'd0);
        step(1);
        chk("t1_first_req", 32'(u_if.imem_req_valid), 32'd1);
        chk("t1_first_addr", u_if.imem_req_addr, 32'h0);
        step(12);
        chk("t1_del_count", 32'(del_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_pc", del_pc[i], 32'(i * 4));
            chk("t1_word", del_word[i], memf(32'(i * 4)));
            if (i > 0) chk("t1_spacing", 32'(del_cyc[i] - del_cyc[i-1]), 32'd2);
        end
        chk("t1_wrap_a0", req2_log[0], 32'hFFFF_FFF8);
        chk("t1_wrap_a1", req2_log[1], 32'hFFFF_FFFC);
        chk("t1_wrap_a2", req2_log[2], 32'h0000_0000);

        // T2: decode backpressure
        u_if.inst_ready = 1'b0;
        do_reset();
        step(10);
        chk("t2_req_count", 32'(req_log.size()), 32'd2);
        chk("t2_req_idle", 32'(u_if.imem_req_valid), 32'd0);
        chk("t2_head_pc", u_if.inst_pc, 32'h0);
        u_if.inst_ready = 1'b1;
        step(8);
        chk("t2_drain0", del_pc[0], 32'h0);
        chk("t2_drain1", del_pc[1], 32'h4);
        chk("t2_resume", req_log[2], 32'h8);

        // T3: redirect while waiting on pc 8
        mem_delay = 3;
        do_reset();
        wait_req(3, 40, "t3_wait_pc8");
        chk("t3_waiting_on", req_log[2], 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        step(15);
        chk("t3_next_addr", req_log[3], 32'h100);
        n8 = 0;
        foreach (del_pc[i]) if (del_pc[i] == 32'h8) n8++;
        chk("t3_no_pc8", 32'(n8), 32'd0);
        chk("t3_del0", del_pc[0], 32'h0);
        chk("t3_del1", del_pc[1], 32'h4);
        chk("t3_del2", del_pc[2], 32'h100);

        // T4a: unaligned redirect from IDLE
        mem_delay = 1; stall = 1'b1;
        do_reset();
        step(3);
        chk("t4_stall_no_req", 32'(req_log.size()), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h203; stall = 1'b0;
        step(1);
        redirect_valid = 1'b0;
        chk("t4_req_valid", 32'(u_if.imem_req_valid), 32'd1);
        chk("t4_req_addr", u_if.imem_req_addr, 32'h200);

        // T4b: redirect coinciding with the stale response in DROP
        mem_auto = 1'b0; man_rsp = 1'b0;
        do_reset();
        wait_req(1, 10, "t4b_wait_pc0");
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step(1);
        redirect_pc = 32'h400; man_rsp = 1'b1; man_data = memf(32'h0);
        step(1);
        redirect_valid = 1'b0; man_rsp = 1'b0;
        chk("t4b_req_valid", 32'(u_if.imem_req_valid), 32'd1);
        chk("t4b_req_addr", u_if.imem_req_addr, 32'h400);
        wait_req(2, 10, "t4b_wait_400");
        chk("t4b_log1", req_log[1], 32'h400);
        man_rsp = 1'b1; man_data = memf(32'h400);
        step(1);
        man_rsp = 1'b0;
        step(3);
        chk("t4b_del_count", 32'(del_pc.size()), 32'd1);
        chk("t4b_del_pc", del_pc[0], 32'h400);
        chk("t4b_del_word", del_word[0], memf(32'h400));

        // T5: reset asserted mid-WAIT, late response after release
        mem_auto = 1'b1; mem_delay = 4; u_if.inst_ready = 1'b0;
        do_reset();
        wait_req(2, 20, "t5_wait_pc4");
        chk("t5_pre_inst_valid", 32'(u_if.inst_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_req_valid", 32'(u_if.imem_req_valid), 32'd0);
        chk("t5_async_inst_valid", 32'(u_if.inst_valid), 32'd0);
        chk("t5_async_addr", u_if.imem_req_addr, 32'h0);
        chk("t5_async_inst_pc", u_if.inst_pc, 32'h0);
        step(1);
        mem_auto = 1'b0; man_rsp = 1'b1; man_data = 32'hDEAD_BEEF;
        u_if.imem_req_ready = 1'b0;
        clear_logs();
        rst_n = 1'b1;
        step(2);
        man_rsp = 1'b0; u_if.imem_req_ready = 1'b1;
        mem_auto = 1'b1; mem_delay = 1; u_if.inst_ready = 1'b1;
        step(6);
        chk("t5_restart_addr", req_log[0], 32'h0);
        chk("t5_first_pc", del_pc[0], 32'h0);
        chk("t5_first_word", del_word[0], memf(32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
